// File: rtl/pipe_hazard_ctrl.sv
// Hazard/sequencing controller for the 5-stage pipeline: load-use stall, branch flush, external hold.
// Control outputs are combinational (zero latency); state and event counters update on the rising clk edge.
module pipe_hazard_ctrl #(
   parameter int LOAD_STALL_CYCLES = 1,
   parameter int CNT_W             = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [2:0]       id_rs,
   input  logic [2:0]       id_rt,
   input  logic             id_uses_rs,
   input  logic             id_uses_rt,
   input  logic             idex_mem_read,
   input  logic [2:0]       idex_rt,
   input  logic             exmem_branch,
   input  logic             exmem_zero,
   input  logic             ext_hold,
   input  logic             clr_cnt,
   output logic             pc_write,
   output logic             ifid_write,
   output logic             pipe_en,
   output logic             idex_bubble,
   output logic             pc_src,
   output logic             ifid_flush,
   output logic             idex_flush,
   output logic             exmem_flush,
   output logic [1:0]       state,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
);

   typedef enum logic [1:0] {
      ST_RUN   = 2'b00,
      ST_STALL = 2'b01,
      ST_HOLD  = 2'b10
   } state_t;

   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   state_t           state_q, state_d, saved_q, saved_d, cur_st, state_o;
   logic [1:0]       rem_q, rem_d;
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;
   logic             hazard, taken, stall_inc, flush_inc;

   // R0 is hardwired zero, so a load into it never creates a dependency.
   assign hazard = idex_mem_read && (idex_rt != 3'd0) &&
                   ((id_uses_rs && (id_rs == idex_rt)) || (id_uses_rt && (id_rt == idex_rt)));
   assign taken  = exmem_branch && exmem_zero;
   assign cur_st = (state_q == ST_HOLD) ? saved_q : state_q;

   always_comb begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      pipe_en     = 1'b0;
      idex_bubble = 1'b0;
      pc_src      = 1'b0;
      ifid_flush  = 1'b0;
      idex_flush  = 1'b0;
      exmem_flush = 1'b0;
      stall_inc   = 1'b0;
      flush_inc   = 1'b0;
      state_o     = cur_st;
      state_d     = state_q;
      saved_d     = saved_q;
      rem_d       = rem_q;
      if (!rst_n) begin
         state_o = ST_RUN;
      end else if (ext_hold) begin
         state_o = ST_HOLD;
         state_d = ST_HOLD;
         if (state_q != ST_HOLD) saved_d = state_q;
      end else if (taken) begin
         pc_src      = 1'b1;
         pc_write    = 1'b1;
         ifid_write  = 1'b1;
         pipe_en     = 1'b1;
         ifid_flush  = 1'b1;
         idex_flush  = 1'b1;
         exmem_flush = 1'b1;
         flush_inc   = 1'b1;
         rem_d       = 2'd0;
         state_d     = ST_RUN;
      end else if (cur_st == ST_STALL) begin
         pipe_en     = 1'b1;
         idex_bubble = 1'b1;
         stall_inc   = 1'b1;
         rem_d       = rem_q - 2'd1;
         state_d     = (rem_q <= 2'd1) ? ST_RUN : ST_STALL;
      end else if (hazard) begin
         pipe_en     = 1'b1;
         idex_bubble = 1'b1;
         stall_inc   = 1'b1;
         if (LOAD_STALL_CYCLES > 1) begin
            rem_d   = 2'(LOAD_STALL_CYCLES - 1);
            state_d = ST_STALL;
         end else begin
            state_d = ST_RUN;
         end
      end else begin
         pc_write   = 1'b1;
         ifid_write = 1'b1;
         pipe_en    = 1'b1;
         state_d    = ST_RUN;
      end
   end

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      flush_cnt_d = flush_cnt_q;
      if (clr_cnt) begin
         stall_cnt_d = '0;
         flush_cnt_d = '0;
      end else begin
         if (stall_inc && (stall_cnt_q != CNT_MAX)) stall_cnt_d = stall_cnt_q + CNT_ONE;
         if (flush_inc && (flush_cnt_q != CNT_MAX)) flush_cnt_d = flush_cnt_q + CNT_ONE;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_RUN;
         saved_q     <= ST_RUN;
         rem_q       <= 2'd0;
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         saved_q     <= saved_d;
         rem_q       <= rem_d;
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   assign state     = state_o;
   assign stall_cnt = stall_cnt_q;
   assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench: three controller instances (L=1, L=3, L=3 with 2-bit counters) share one stimulus.
module tb_pipe_hazard_ctrl;

   localparam logic [7:0] C_ZERO = 8'b0000_0000;
   localparam logic [7:0] C_IDLE = 8'b1110_0000;
   localparam logic [7:0] C_BUB  = 8'b0011_0000;
   localparam logic [7:0] C_FLU  = 8'b1110_1111;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [2:0] id_rs = 3'd0, id_rt = 3'd0, idex_rt = 3'd0;
   logic       id_uses_rs = 1'b0, id_uses_rt = 1'b0, idex_mem_read = 1'b0;
   logic       exmem_branch = 1'b0, exmem_zero = 1'b0, ext_hold = 1'b0, clr_cnt = 1'b0;

   logic [7:0]  a_ctl, b_ctl, c_ctl;
   logic [1:0]  a_st, b_st, c_st;
   logic [15:0] a_sc, a_fc, b_sc, b_fc;
   logic [1:0]  c_sc, c_fc;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   pipe_hazard_ctrl #(.LOAD_STALL_CYCLES(1), .CNT_W(16)) u_a (
      .clk(clk), .rst_n(rst_n), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs),
      .id_uses_rt(id_uses_rt), .idex_mem_read(idex_mem_read), .idex_rt(idex_rt),
      .exmem_branch(exmem_branch), .exmem_zero(exmem_zero), .ext_hold(ext_hold), .clr_cnt(clr_cnt),
      .pc_write(a_ctl[7]), .ifid_write(a_ctl[6]), .pipe_en(a_ctl[5]), .idex_bubble(a_ctl[4]),
      .pc_src(a_ctl[3]), .ifid_flush(a_ctl[2]), .idex_flush(a_ctl[1]), .exmem_flush(a_ctl[0]),
      .state(a_st), .stall_cnt(a_sc), .flush_cnt(a_fc));

   pipe_hazard_ctrl #(.LOAD_STALL_CYCLES(3), .CNT_W(16)) u_b (
      .clk(clk), .rst_n(rst_n), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs),
      .id_uses_rt(id_uses_rt), .idex_mem_read(idex_mem_read), .idex_rt(idex_rt),
      .exmem_branch(exmem_branch), .exmem_zero(exmem_zero), .ext_hold(ext_hold), .clr_cnt(clr_cnt),
      .pc_write(b_ctl[7]), .ifid_write(b_ctl[6]), .pipe_en(b_ctl[5]), .idex_bubble(b_ctl[4]),
      .pc_src(b_ctl[3]), .ifid_flush(b_ctl[2]), .idex_flush(b_ctl[1]), .exmem_flush(b_ctl[0]),
      .state(b_st), .stall_cnt(b_sc), .flush_cnt(b_fc));

   pipe_hazard_ctrl #(.LOAD_STALL_CYCLES(3), .CNT_W(2)) u_c (
      .clk(clk), .rst_n(rst_n), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs),
      .id_uses_rt(id_uses_rt), .idex_mem_read(idex_mem_read), .idex_rt(idex_rt),
      .exmem_branch(exmem_branch), .exmem_zero(exmem_zero), .ext_hold(ext_hold), .clr_cnt(clr_cnt),
      .pc_write(c_ctl[7]), .ifid_write(c_ctl[6]), .pipe_en(c_ctl[5]), .idex_bubble(c_ctl[4]),
      .pc_src(c_ctl[3]), .ifid_flush(c_ctl[2]), .idex_flush(c_ctl[1]), .exmem_flush(c_ctl[0]),
      .state(c_st), .stall_cnt(c_sc), .flush_cnt(c_fc));

   task automatic idle_inputs();
      id_rs = 3'd0; id_rt = 3'd0; idex_rt = 3'd0;
      id_uses_rs = 1'b0; id_uses_rt = 1'b0; idex_mem_read = 1'b0;
      exmem_branch = 1'b0; exmem_zero = 1'b0; ext_hold = 1'b0; clr_cnt = 1'b0;
   endtask

   task automatic set_hazard();
      idex_mem_read = 1'b1; idex_rt = 3'd3; id_rs = 3'd3; id_uses_rs = 1'b1;
   endtask

   // Leaves the bench 2 time units after the edge at which reset was released.
   task automatic do_reset();
      idle_inputs();
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      #1;
   endtask

   task automatic next_cycle();
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      idle_inputs();
      @(posedge clk); #1;
      rst_n = 1'b0;
      ext_hold = 1'b1;
      #1;
      total++; if (a_ctl !== C_ZERO) begin bad++; $display("FAIL reset_ctl got=%b exp=%b", a_ctl, C_ZERO); end
      total++; if (a_st !== 2'b00) begin bad++; $display("FAIL reset_state got=%b exp=00", a_st); end
      total++; if (a_sc !== 16'd0 || a_fc !== 16'd0) begin bad++; $display("FAIL reset_cnt got=%0d/%0d exp=0/0", a_sc, a_fc); end
      ext_hold = 1'b0;
      rst_n = 1'b1;
      next_cycle();
      total++; if (a_ctl !== C_IDLE) begin bad++; $display("FAIL post_reset_idle got=%b exp=%b", a_ctl, C_IDLE); end
   endtask

   task automatic test_load_use_l1();
      do_reset();
      set_hazard();
      #1;
      total++; if (a_ctl !== C_BUB) begin bad++; $display("FAIL l1_bubble got=%b exp=%b", a_ctl, C_BUB); end
      next_cycle();
      idle_inputs();
      #1;
      total++; if (a_ctl !== C_IDLE) begin bad++; $display("FAIL l1_after got=%b exp=%b", a_ctl, C_IDLE); end
      total++; if (a_sc !== 16'd1) begin bad++; $display("FAIL l1_stall_cnt got=%0d exp=1", a_sc); end
   endtask

   task automatic test_hold_l3();
      do_reset();
      set_hazard();
      #1;
      total++; if (b_ctl !== C_BUB || b_st !== 2'b00) begin bad++; $display("FAIL hold_c0 got=%b/%b exp=%b/00", b_ctl, b_st, C_BUB); end
      next_cycle();
      total++; if (b_ctl !== C_BUB || b_st !== 2'b01) begin bad++; $display("FAIL hold_c1 got=%b/%b exp=%b/01", b_ctl, b_st, C_BUB); end
      next_cycle();
      ext_hold = 1'b1;
      #1;
      total++; if (b_ctl !== C_ZERO || b_st !== 2'b10) begin bad++; $display("FAIL hold_c2 got=%b/%b exp=%b/10", b_ctl, b_st, C_ZERO); end
      next_cycle();
      total++; if (b_ctl !== C_ZERO || b_st !== 2'b10) begin bad++; $display("FAIL hold_c3 got=%b/%b exp=%b/10", b_ctl, b_st, C_ZERO); end
      total++; if (b_sc !== 16'd2) begin bad++; $display("FAIL hold_frozen_cnt got=%0d exp=2", b_sc); end
      next_cycle();
      ext_hold = 1'b0;
      #1;
      total++; if (b_ctl !== C_BUB || b_st !== 2'b01) begin bad++; $display("FAIL hold_c4 got=%b/%b exp=%b/01", b_ctl, b_st, C_BUB); end
      next_cycle();
      idle_inputs();
      #1;
      total++; if (b_ctl !== C_IDLE || b_st !== 2'b00) begin bad++; $display("FAIL hold_c5 got=%b/%b exp=%b/00", b_ctl, b_st, C_IDLE); end
      total++; if (b_sc !== 16'd3) begin bad++; $display("FAIL hold_stall_cnt got=%0d exp=3", b_sc); end
   endtask

   task automatic test_no_hazard();
      do_reset();
      idex_mem_read = 1'b1; idex_rt = 3'd0; id_rs = 3'd0; id_uses_rs = 1'b1;
      #1;
      total++; if (a_ctl !== C_IDLE) begin bad++; $display("FAIL r0_no_stall got=%b exp=%b", a_ctl, C_IDLE); end
      next_cycle();
      idex_rt = 3'd3; id_rs = 3'd3; id_uses_rs = 1'b0; id_rt = 3'd5; id_uses_rt = 1'b1;
      #1;
      total++; if (a_ctl !== C_IDLE) begin bad++; $display("FAIL unused_rs_no_stall got=%b exp=%b", a_ctl, C_IDLE); end
      next_cycle();
      idle_inputs();
      #1;
      total++; if (a_sc !== 16'd0) begin bad++; $display("FAIL no_hazard_cnt got=%0d exp=0", a_sc); end
      idex_mem_read = 1'b1; idex_rt = 3'd6; id_rt = 3'd6; id_uses_rt = 1'b1;
      #1;
      total++; if (a_ctl !== C_BUB) begin bad++; $display("FAIL rt_match_stall got=%b exp=%b", a_ctl, C_BUB); end
      next_cycle();
      idle_inputs();
   endtask

   task automatic test_branch_in_stall();
      do_reset();
      set_hazard();
      next_cycle();
      exmem_branch = 1'b1; exmem_zero = 1'b1;
      #1;
      total++; if (b_ctl !== C_FLU || b_st !== 2'b01) begin bad++; $display("FAIL br_stall_flush got=%b/%b exp=%b/01", b_ctl, b_st, C_FLU); end
      next_cycle();
      idle_inputs();
      #1;
      total++; if (b_ctl !== C_IDLE || b_st !== 2'b00) begin bad++; $display("FAIL br_stall_after got=%b/%b exp=%b/00", b_ctl, b_st, C_IDLE); end
      total++; if (b_fc !== 16'd1 || b_sc !== 16'd1) begin bad++; $display("FAIL br_stall_cnts got=%0d/%0d exp=1/1", b_fc, b_sc); end
   endtask

   task automatic test_branch();
      do_reset();
      exmem_branch = 1'b1; exmem_zero = 1'b0;
      #1;
      total++; if (a_ctl !== C_IDLE) begin bad++; $display("FAIL not_taken got=%b exp=%b", a_ctl, C_IDLE); end
      exmem_zero = 1'b1; ext_hold = 1'b1;
      #1;
      total++; if (a_ctl !== C_ZERO || a_st !== 2'b10) begin bad++; $display("FAIL hold_over_taken got=%b/%b exp=%b/10", a_ctl, a_st, C_ZERO); end
      next_cycle();
      ext_hold = 1'b0;
      set_hazard();
      #1;
      total++; if (a_ctl !== C_FLU) begin bad++; $display("FAIL taken_over_hazard got=%b exp=%b", a_ctl, C_FLU); end
      next_cycle();
      idle_inputs();
      #1;
      total++; if (a_fc !== 16'd1 || a_sc !== 16'd0) begin bad++; $display("FAIL taken_cnts got=%0d/%0d exp=1/0", a_fc, a_sc); end
   endtask

   task automatic test_saturate_and_reset();
      do_reset();
      set_hazard();
      for (int i = 0; i < 5; i++) next_cycle();
      total++; if (c_sc !== 2'd3) begin bad++; $display("FAIL sat_cnt got=%0d exp=3", c_sc); end
      clr_cnt = 1'b1;
      next_cycle();
      clr_cnt = 1'b0;
      #1;
      total++; if (c_sc !== 2'd0) begin bad++; $display("FAIL clr_cnt got=%0d exp=0", c_sc); end
      next_cycle();
      total++; if (c_st !== 2'b01 || c_sc !== 2'd1) begin bad++; $display("FAIL pre_rst_stall got=%b/%0d exp=01/1", c_st, c_sc); end
      rst_n = 1'b0;
      #1;
      total++; if (c_st !== 2'b00 || c_sc !== 2'd0 || c_ctl !== C_ZERO) begin bad++; $display("FAIL mid_stall_rst got=%b/%0d/%b exp=00/0/%b", c_st, c_sc, c_ctl, C_ZERO); end
      idle_inputs();
      next_cycle();
      rst_n = 1'b1;
      next_cycle();
      total++; if (c_ctl !== C_IDLE || c_st !== 2'b00) begin bad++; $display("FAIL rst_no_resume got=%b/%b exp=%b/00", c_ctl, c_st, C_IDLE); end
   endtask

   initial begin
      test_reset();
      test_load_use_l1();
      test_hold_l3();
      test_no_hazard();
      test_branch_in_stall();
      test_branch();
      test_saturate_and_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
